// File: rtl/pipe_stage_elastic.sv
// ============================================================================
// pipe_stage_elastic : valid/ready pipeline stage, optional two-entry skid
// Optional STALL_CNT backpressure counter enabled by PIPE_STAGE_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_stage_elastic #(
  parameter int                   BIT_WIDTH     = 32,
  parameter logic [BIT_WIDTH-1:0] DEFAULT_VALUE = {BIT_WIDTH{1'b0}},
  parameter bit                   SKID_EN       = 1'b1,
  parameter int                   CNT_WIDTH     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLEAR,
  input  logic                 STALL,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [BIT_WIDTH-1:0] IN_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [BIT_WIDTH-1:0] OUT_DATA,
  output logic [1:0]           OCCUPANCY,
  output logic [CNT_WIDTH-1:0] STALL_CNT
);

  logic                 main_valid;
  logic [BIT_WIDTH-1:0] main_data;
  logic                 in_ready;
  logic                 out_valid;
  logic                 accept;
  logic                 emit;

  assign out_valid = main_valid & ~STALL & ~CLEAR;
  assign accept    = IN_VALID & in_ready;
  assign emit      = out_valid & OUT_READY;

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid;
  assign OUT_DATA  = main_data;

  generate
    if (SKID_EN) begin : g_skid
      logic                 skid_valid;
      logic [BIT_WIDTH-1:0] skid_data;

      // Ready depends only on registered state, so OUT_READY never reaches IN_READY.
      assign in_ready  = ~skid_valid & ~STALL & ~CLEAR;
      assign OCCUPANCY = {skid_valid, main_valid & ~skid_valid};

      always_ff @(posedge CLK) begin
        if (RST || CLEAR) begin
          main_valid <= 1'b0;
          main_data  <= DEFAULT_VALUE;
          skid_valid <= 1'b0;
          skid_data  <= DEFAULT_VALUE;
        end else if (!STALL) begin
          if (skid_valid) begin
            if (emit) begin
              main_data  <= skid_data;
              skid_valid <= 1'b0;
            end
          end else if (main_valid) begin
            if (accept && emit) begin
              main_data <= IN_DATA;
            end else if (accept) begin
              skid_data  <= IN_DATA;
              skid_valid <= 1'b1;
            end else if (emit) begin
              main_valid <= 1'b0;
            end
          end else if (accept) begin
            main_data  <= IN_DATA;
            main_valid <= 1'b1;
          end
        end
      end
    end else begin : g_pass
      assign in_ready  = (~main_valid | OUT_READY) & ~STALL & ~CLEAR;
      assign OCCUPANCY = {1'b0, main_valid};

      always_ff @(posedge CLK) begin
        if (RST || CLEAR) begin
          main_valid <= 1'b0;
          main_data  <= DEFAULT_VALUE;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_data  <= IN_DATA;
        end else if (emit) begin
          main_valid <= 1'b0;
        end
      end
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt;

  // Saturating; CLEAR intentionally leaves it alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (IN_VALID && !in_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign STALL_CNT = stall_cnt;
`else
  assign STALL_CNT = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench: skid-mode stage driven from a vector table, pass-through stage
// with a 4-bit counter driven by a hand-written sequence.
`default_nettype none

module tb_pipe_stage_elastic;

`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_clear, a_stall, a_iv, a_ir, a_or, a_ov;
  logic [7:0] a_id, a_od;
  logic [1:0] a_occ;
  logic [15:0] a_cnt;

  logic       b_rst, b_clear, b_stall, b_iv, b_ir, b_or, b_ov;
  logic [7:0] b_id, b_od;
  logic [1:0] b_occ;
  logic [3:0] b_cnt;

  pipe_stage_elastic #(
    .BIT_WIDTH(8), .DEFAULT_VALUE(8'hA5), .SKID_EN(1'b1), .CNT_WIDTH(16)
  ) dut_a (
    .CLK(clk), .RST(a_rst), .CLEAR(a_clear), .STALL(a_stall),
    .IN_VALID(a_iv), .IN_READY(a_ir), .IN_DATA(a_id),
    .OUT_VALID(a_ov), .OUT_READY(a_or), .OUT_DATA(a_od),
    .OCCUPANCY(a_occ), .STALL_CNT(a_cnt)
  );

  pipe_stage_elastic #(
    .BIT_WIDTH(8), .DEFAULT_VALUE(8'hA5), .SKID_EN(1'b0), .CNT_WIDTH(4)
  ) dut_b (
    .CLK(clk), .RST(b_rst), .CLEAR(b_clear), .STALL(b_stall),
    .IN_VALID(b_iv), .IN_READY(b_ir), .IN_DATA(b_id),
    .OUT_VALID(b_ov), .OUT_READY(b_or), .OUT_DATA(b_od),
    .OCCUPANCY(b_occ), .STALL_CNT(b_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       st, cl, iv;
    logic [7:0] id;
    logic       orr;
    logic       ov;
    logic [7:0] od;
    logic       ir;
    logic [1:0] occ;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic cl, input logic iv,
                              input logic [7:0] id, input logic orr,
                              input logic ov, input logic [7:0] od,
                              input logic ir, input logic [1:0] occ);
    vec_t v;
    v.st = st; v.cl = cl; v.iv = iv; v.id = id; v.orr = orr;
    v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
    return v;
  endfunction

  vec_t vecs[$];
  int   a_model;
  int   b_model;

  initial begin
    // Expected outputs are those seen before the edge that follows the inputs.
    vecs.push_back(mk(0,0,1,8'h01,1, 0,8'hA5,1,2'd0));
    for (int k = 1; k <= 15; k++)
      vecs.push_back(mk(0,0,1,8'(k+1),1, 1,8'(k),1,2'd1));
    vecs.push_back(mk(0,0,0,8'h00,1, 1,8'h10,1,2'd1));
    // backpressure
    vecs.push_back(mk(0,0,1,8'h11,0, 0,8'h10,1,2'd0));
    vecs.push_back(mk(0,0,1,8'h22,0, 1,8'h11,1,2'd1));
    vecs.push_back(mk(0,0,1,8'h33,0, 1,8'h11,0,2'd2));
    vecs.push_back(mk(0,0,1,8'h33,0, 1,8'h11,0,2'd2));
    vecs.push_back(mk(0,0,1,8'h33,1, 1,8'h11,0,2'd2));
    vecs.push_back(mk(0,0,1,8'h33,1, 1,8'h22,1,2'd1));
    vecs.push_back(mk(0,0,0,8'h00,1, 1,8'h33,1,2'd1));
    // flush while full
    vecs.push_back(mk(0,0,1,8'h66,0, 0,8'h33,1,2'd0));
    vecs.push_back(mk(0,0,1,8'h77,0, 1,8'h66,1,2'd1));
    vecs.push_back(mk(0,1,1,8'h44,1, 0,8'h66,0,2'd2));
    vecs.push_back(mk(0,0,0,8'h00,1, 0,8'hA5,1,2'd0));
    // stall holding one entry
    vecs.push_back(mk(0,0,1,8'h55,0, 0,8'hA5,1,2'd0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,0,1,8'h99,1, 0,8'h55,0,2'd1));
    vecs.push_back(mk(0,0,0,8'h00,1, 1,8'h55,1,2'd1));
    vecs.push_back(mk(0,0,0,8'h00,0, 0,8'h55,1,2'd0));

    a_rst = 1'b1; a_clear = 1'b0; a_stall = 1'b0; a_iv = 1'b0; a_id = 8'h00; a_or = 1'b0;
    b_rst = 1'b1; b_clear = 1'b0; b_stall = 1'b0; b_iv = 1'b0; b_id = 8'h00; b_or = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("a_reset out_valid", 32'(a_ov), 32'd0);
    chk("a_reset out_data", 32'(a_od), 32'hA5);
    chk("a_reset occupancy", 32'(a_occ), 32'd0);
    chk("a_reset in_ready", 32'(a_ir), 32'd1);
    chk("a_reset stall_cnt", 32'(a_cnt), 32'd0);
    chk("b_reset out_data", 32'(b_od), 32'hA5);
    chk("b_reset in_ready", 32'(b_ir), 32'd1);

    a_model = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      a_stall = vecs[i].st; a_clear = vecs[i].cl; a_iv = vecs[i].iv;
      a_id = vecs[i].id; a_or = vecs[i].orr;
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(a_ov), 32'(vecs[i].ov));
      chk($sformatf("v%0d out_data", i), 32'(a_od), 32'(vecs[i].od));
      chk($sformatf("v%0d in_ready", i), 32'(a_ir), 32'(vecs[i].ir));
      chk($sformatf("v%0d occupancy", i), 32'(a_occ), 32'(vecs[i].occ));
      chk($sformatf("v%0d stall_cnt", i), 32'(a_cnt), PERF ? 32'(a_model) : 32'd0);
      if (vecs[i].iv && !vecs[i].ir && a_model < 65535) a_model++;
      @(negedge clk);
    end

    // Reset while two entries are held.
    a_stall = 1'b0; a_clear = 1'b0; a_or = 1'b0; a_iv = 1'b1; a_id = 8'hAA;
    @(negedge clk);
    a_id = 8'hBB;
    @(negedge clk);
    chk("a_midreset full occupancy", 32'(a_occ), 32'd2);
    a_iv = 1'b0; a_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    #1;
    chk("a_midreset out_valid", 32'(a_ov), 32'd0);
    chk("a_midreset out_data", 32'(a_od), 32'hA5);
    chk("a_midreset occupancy", 32'(a_occ), 32'd0);
    chk("a_midreset in_ready", 32'(a_ir), 32'd1);
    chk("a_midreset stall_cnt", 32'(a_cnt), 32'd0);

    // Pass-through stage held full for 20 cycles; 4-bit counter must saturate.
    b_model = 0;
    b_or = 1'b0; b_iv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_id = 8'(i + 1);
      #1;
      chk($sformatf("b%0d occupancy", i), 32'(b_occ), (i == 0) ? 32'd0 : 32'd1);
      chk($sformatf("b%0d in_ready", i), 32'(b_ir), (i == 0) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk($sformatf("b%0d out_valid", i), 32'(b_ov), 32'd1);
        chk($sformatf("b%0d out_data", i), 32'(b_od), 32'h01);
      end
      if (i > 0 && b_model < 15) b_model++;
      @(negedge clk);
    end
    #1;
    chk("b stall_cnt saturated", 32'(b_cnt), PERF ? 32'(b_model) : 32'd0);

    b_or = 1'b1; b_id = 8'hC3;
    #1;
    chk("b full ready passthrough", 32'(b_ir), 32'd1);
    chk("b full out_data", 32'(b_od), 32'h01);
    @(negedge clk);
    b_iv = 1'b0;
    #1;
    chk("b replaced out_data", 32'(b_od), 32'hC3);
    chk("b replaced out_valid", 32'(b_ov), 32'd1);
    @(negedge clk);
    #1;
    chk("b drained occupancy", 32'(b_occ), 32'd0);
    chk("b drained out_valid", 32'(b_ov), 32'd0);
    chk("b stall_cnt held", 32'(b_cnt), PERF ? 32'd15 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
